// File: rtl/nanorisc_trace_monitor.sv
// nanorisc_trace_monitor: captures {cycle, pc, instruction} per RUN cycle into a FIFO trace buffer
module nanorisc_trace_monitor #(
  parameter int ADDR_WIDTH = 8,
  parameter int INSTR_WIDTH = 8,
  parameter int CNT_WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int MAX_CYCLES = 70,
  parameter int WRAP_MODE = 0,
  localparam int AW = $clog2(DEPTH),
  localparam int EW = CNT_WIDTH + ADDR_WIDTH + INSTR_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   clear,
  input  logic [ADDR_WIDTH-1:0]  pc,
  input  logic [INSTR_WIDTH-1:0] instruction,
  input  logic                   bp_enable,
  input  logic [ADDR_WIDTH-1:0]  bp_addr,
  input  logic                   rd_req,
  output logic                   rd_valid,
  output logic [EW-1:0]          rd_data,
  output logic [CNT_WIDTH-1:0]   cycle_count,
  output logic [AW:0]            level,
  output logic                   running,
  output logic                   halted,
  output logic                   overflow
);
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  state_t state, state_next;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop, full, stop, wr_en, drop_oldest;
  assign full = level == (AW+1)'(DEPTH);
  assign push = state == RUN && !clear;
  assign pop = rd_req && level != '0 && !clear;
  assign stop = cycle_count == CNT_WIDTH'(MAX_CYCLES) || (bp_enable && pc == bp_addr);
  assign drop_oldest = push && full && !pop && WRAP_MODE != 0;
  assign wr_en = push && (!full || pop || WRAP_MODE != 0);
  assign running = state == RUN;
  assign halted = state == HALTED;
  // Next state: clear always wins, start only matters in IDLE, halt on limit or breakpoint
  always_comb begin
    state_next = clear ? IDLE
               : (state == IDLE && start) ? RUN
               : (state == RUN && stop) ? HALTED
               : state;
  end
  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_next;
  end
  // Trace storage; contents need no reset because level gates every read
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= {cycle_count, pc, instruction};
  end
  // Pointers, occupancy, cycle counter, sticky overflow and read port
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      cycle_count <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      rd_data <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      cycle_count <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (pop) rd_data <= mem[rd_ptr];
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop || drop_oldest) rd_ptr <= rd_ptr + AW'(1);
      level <= (push && !pop && !full) ? level + (AW+1)'(1)
             : (pop && !push) ? level - (AW+1)'(1)
             : level;
      overflow <= overflow | (push && full && !pop);
      cycle_count <= (state == IDLE && start) ? CNT_WIDTH'(1)
                   : (state == RUN && !stop) ? cycle_count + CNT_WIDTH'(1)
                   : cycle_count;
    end
  end
endmodule

// File: tb/tb_nanorisc_trace_monitor.sv
// tb_nanorisc_trace_monitor: directed scenario checks on default, wrap and small-buffer monitors
module tb_nanorisc_trace_monitor;
  logic clock = 1'b0, reset = 1'b0, start = 1'b0, clear = 1'b0, bp_enable = 1'b0, rd_req = 1'b0;
  logic [7:0] pc = '0, instruction = '0, bp_addr = '0;
  logic rv0, rv1, rv2, run0, run1, run2, hlt0, hlt1, hlt2, ov0, ov1, ov2;
  logic [31:0] rd0, rd1, rd2, exp_e;
  logic [15:0] cc0, cc1, cc2;
  logic [4:0] lv0;
  logic [2:0] lv1, lv2;
  logic [7:0] bp_seq [4] = '{8'd0, 8'd1, 8'd2, 8'd5};
  int vectors = 0, miscompares = 0;

  always #5 clock = ~clock;

  nanorisc_trace_monitor d0 (.clock(clock), .reset(reset), .start(start), .clear(clear), .pc(pc),
    .instruction(instruction), .bp_enable(bp_enable), .bp_addr(bp_addr), .rd_req(rd_req),
    .rd_valid(rv0), .rd_data(rd0), .cycle_count(cc0), .level(lv0), .running(run0), .halted(hlt0), .overflow(ov0));
  nanorisc_trace_monitor #(.DEPTH(4), .MAX_CYCLES(10), .WRAP_MODE(1)) d1 (.clock(clock), .reset(reset),
    .start(start), .clear(clear), .pc(pc), .instruction(instruction), .bp_enable(bp_enable), .bp_addr(bp_addr),
    .rd_req(rd_req), .rd_valid(rv1), .rd_data(rd1), .cycle_count(cc1), .level(lv1), .running(run1),
    .halted(hlt1), .overflow(ov1));
  nanorisc_trace_monitor #(.DEPTH(4)) d2 (.clock(clock), .reset(reset), .start(start), .clear(clear), .pc(pc),
    .instruction(instruction), .bp_enable(bp_enable), .bp_addr(bp_addr), .rd_req(rd_req),
    .rd_valid(rv2), .rd_data(rd2), .cycle_count(cc2), .level(lv2), .running(run2), .halted(hlt2), .overflow(ov2));

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_pc(input logic [7:0] p);
    pc = p;
    instruction = p ^ 8'hA5;
  endtask

  task automatic do_clear();
    start = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    vectors++; if (run0 !== 1'b0 || hlt0 !== 1'b0) begin miscompares++; $display("FAIL reset_state run=%b halt=%b want 0 0", run0, hlt0); end
    vectors++; if (cc0 !== 16'd0 || lv0 !== 5'd0) begin miscompares++; $display("FAIL reset_count cc=%0d lvl=%0d want 0 0", cc0, lv0); end
    vectors++; if (rv0 !== 1'b0 || rd0 !== 32'd0 || ov0 !== 1'b0) begin miscompares++; $display("FAIL reset_read rv=%b rd=%h ov=%b want 0", rv0, rd0, ov0); end
    #4 reset = 1'b0;
  endtask

  task automatic test_default_run();
    do_clear();
    start = 1'b1;
    set_pc(8'd0);
    step();
    vectors++; if (run0 !== 1'b1 || cc0 !== 16'd1) begin miscompares++; $display("FAIL run_entry run=%b cc=%0d want 1 1", run0, cc0); end
    for (int k = 1; k <= 70; k++) begin
      step();
      set_pc(8'(k));
      if (k == 69) begin
        vectors++; if (hlt0 !== 1'b0 || cc0 !== 16'd70) begin miscompares++; $display("FAIL pre_halt halt=%b cc=%0d want 0 70", hlt0, cc0); end
      end
    end
    vectors++; if (hlt0 !== 1'b1 || cc0 !== 16'd70) begin miscompares++; $display("FAIL max_halt halt=%b cc=%0d want 1 70", hlt0, cc0); end
    vectors++; if (lv0 !== 5'd16 || ov0 !== 1'b1) begin miscompares++; $display("FAIL full_drop lvl=%0d ov=%b want 16 1", lv0, ov0); end
    step();
    vectors++; if (hlt0 !== 1'b1 || cc0 !== 16'd70) begin miscompares++; $display("FAIL halt_hold halt=%b cc=%0d want 1 70", hlt0, cc0); end
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rd_req = 1'b1;
      step();
      rd_req = 1'b0;
      exp_e = {16'(i + 1), 8'(i), 8'(i) ^ 8'hA5};
      vectors++; if (rv0 !== 1'b1 || rd0 !== exp_e) begin miscompares++; $display("FAIL pop%0d rv=%b rd=%h want 1 %h", i, rv0, rd0, exp_e); end
      step();
      if (i == 0) begin
        vectors++; if (rv0 !== 1'b0 || rd0 !== exp_e) begin miscompares++; $display("FAIL rd_hold rv=%b rd=%h want 0 %h", rv0, rd0, exp_e); end
      end
    end
    vectors++; if (lv0 !== 5'd0) begin miscompares++; $display("FAIL drained lvl=%0d want 0", lv0); end
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    vectors++; if (rv0 !== 1'b0) begin miscompares++; $display("FAIL empty_pop rv=%b want 0", rv0); end
  endtask

  task automatic test_wrap();
    do_clear();
    start = 1'b1;
    set_pc(8'd0);
    step();
    for (int k = 1; k <= 10; k++) begin
      step();
      set_pc(8'(k));
    end
    start = 1'b0;
    vectors++; if (hlt1 !== 1'b1 || cc1 !== 16'd10) begin miscompares++; $display("FAIL wrap_halt halt=%b cc=%0d want 1 10", hlt1, cc1); end
    vectors++; if (lv1 !== 3'd4 || ov1 !== 1'b1) begin miscompares++; $display("FAIL wrap_level lvl=%0d ov=%b want 4 1", lv1, ov1); end
    for (int i = 0; i < 4; i++) begin
      rd_req = 1'b1;
      step();
      rd_req = 1'b0;
      exp_e = {16'(7 + i), 8'(6 + i), 8'(6 + i) ^ 8'hA5};
      vectors++; if (rv1 !== 1'b1 || rd1 !== exp_e) begin miscompares++; $display("FAIL wrap_pop%0d rv=%b rd=%h want 1 %h", i, rv1, rd1, exp_e); end
    end
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    vectors++; if (rv1 !== 1'b0) begin miscompares++; $display("FAIL wrap_empty rv=%b want 0", rv1); end
  endtask

  task automatic test_breakpoint();
    do_clear();
    bp_enable = 1'b1;
    bp_addr = 8'h05;
    start = 1'b1;
    set_pc(bp_seq[0]);
    step();
    for (int j = 0; j < 4; j++) begin
      set_pc(bp_seq[j]);
      step();
      if (j == 2) begin
        vectors++; if (run0 !== 1'b1) begin miscompares++; $display("FAIL bp_early run=%b want 1", run0); end
      end
    end
    bp_enable = 1'b0;
    start = 1'b0;
    vectors++; if (hlt0 !== 1'b1 || cc0 !== 16'd4 || lv0 !== 5'd4) begin miscompares++; $display("FAIL bp_halt halt=%b cc=%0d lvl=%0d want 1 4 4", hlt0, cc0, lv0); end
    for (int i = 0; i < 4; i++) begin
      rd_req = 1'b1;
      step();
      rd_req = 1'b0;
    end
    exp_e = {16'd4, 8'h05, 8'h05 ^ 8'hA5};
    vectors++; if (rv0 !== 1'b1 || rd0 !== exp_e) begin miscompares++; $display("FAIL bp_last rv=%b rd=%h want 1 %h", rv0, rd0, exp_e); end
  endtask

  task automatic test_back_to_back();
    do_clear();
    start = 1'b1;
    set_pc(8'd0);
    step();
    for (int k = 1; k <= 4; k++) begin
      step();
      set_pc(8'(k));
    end
    vectors++; if (lv2 !== 3'd4 || ov2 !== 1'b0 || run2 !== 1'b1) begin miscompares++; $display("FAIL b2b_fill lvl=%0d ov=%b run=%b want 4 0 1", lv2, ov2, run2); end
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    set_pc(8'd5);
    exp_e = {16'd1, 8'd0, 8'hA5};
    vectors++; if (rv2 !== 1'b1 || rd2 !== exp_e) begin miscompares++; $display("FAIL b2b_pop rv=%b rd=%h want 1 %h", rv2, rd2, exp_e); end
    vectors++; if (lv2 !== 3'd4 || ov2 !== 1'b0) begin miscompares++; $display("FAIL b2b_level lvl=%0d ov=%b want 4 0", lv2, ov2); end
    step();
    vectors++; if (lv2 !== 3'd4 || ov2 !== 1'b1) begin miscompares++; $display("FAIL b2b_drop lvl=%0d ov=%b want 4 1", lv2, ov2); end
  endtask

  task automatic test_clear();
    do_clear();
    start = 1'b1;
    set_pc(8'd0);
    step();
    step();
    step();
    vectors++; if (cc0 !== 16'd3 || lv0 !== 5'd2) begin miscompares++; $display("FAIL clr_pre cc=%0d lvl=%0d want 3 2", cc0, lv0); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    vectors++; if (run0 !== 1'b0 || hlt0 !== 1'b0 || lv0 !== 5'd0 || cc0 !== 16'd0) begin miscompares++; $display("FAIL clr_idle run=%b halt=%b lvl=%0d cc=%0d want 0 0 0 0", run0, hlt0, lv0, cc0); end
    step();
    vectors++; if (run0 !== 1'b1 || cc0 !== 16'd1) begin miscompares++; $display("FAIL clr_restart run=%b cc=%0d want 1 1", run0, cc0); end
  endtask

  task automatic test_async_reset();
    do_clear();
    start = 1'b1;
    set_pc(8'd0);
    step();
    step();
    step();
    vectors++; if (lv0 !== 5'd2 || run0 !== 1'b1) begin miscompares++; $display("FAIL ar_pre lvl=%0d run=%b want 2 1", lv0, run0); end
    #2 reset = 1'b1;
    #1;
    vectors++; if (run0 !== 1'b0 || cc0 !== 16'd0 || lv0 !== 5'd0 || ov0 !== 1'b0) begin miscompares++; $display("FAIL ar_now run=%b cc=%0d lvl=%0d ov=%b want 0", run0, cc0, lv0, ov0); end
    vectors++; if (rv0 !== 1'b0 || rd0 !== 32'd0 || hlt0 !== 1'b0) begin miscompares++; $display("FAIL ar_read rv=%b rd=%h halt=%b want 0", rv0, rd0, hlt0); end
    reset = 1'b0;
    start = 1'b0;
    step();
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    vectors++; if (rv0 !== 1'b0 || lv0 !== 5'd0) begin miscompares++; $display("FAIL ar_pop rv=%b lvl=%0d want 0 0", rv0, lv0); end
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_wrap();
    test_breakpoint();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/nanorisc_trace_monitor.md
NANORISC_TRACE_MONITOR -- requirements
Module: nanorisc_trace_monitor

Interface
REQ-001 Parameter ADDR_WIDTH, 8, width of the monitored program counter.
REQ-002 Parameter INSTR_WIDTH, 8, width of the monitored instruction word.
REQ-003 Parameter CNT_WIDTH, 16, width of the cycle counter.
REQ-004 Parameter DEPTH, 16, trace buffer entries; power of two, 2 to 256.
REQ-005 Parameter MAX_CYCLES, 70, cycle limit that forces halt; 1 to 2^CNT_WIDTH-1.
REQ-006 Parameter WRAP_MODE, 0, selects the full-buffer policy: 0 = drop newest, 1 = overwrite oldest.
REQ-007 clock  input  1  sole clock; all state updates on its rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 start  input  1  level; begins a trace run from IDLE.
REQ-010 clear  input  1  synchronous pulse; aborts or ends the run and empties the buffer.
REQ-011 pc  input  ADDR_WIDTH  processor program counter sampled each RUN cycle.
REQ-012 instruction  input  INSTR_WIDTH  instruction fetched at pc.
REQ-013 bp_enable  input  1  enables the PC breakpoint.
REQ-014 bp_addr  input  ADDR_WIDTH  breakpoint address.
REQ-015 rd_req  input  1  pops one trace entry.
REQ-016 rd_valid  output  1  rd_data holds a popped entry this cycle.
REQ-017 rd_data  output  CNT_WIDTH+ADDR_WIDTH+INSTR_WIDTH  popped entry {cycle, pc, instruction}.
REQ-018 cycle_count  output  CNT_WIDTH  RUN cycles elapsed in the current run.
REQ-019 level  output  clog2(DEPTH)+1  entries held in the buffer.
REQ-020 running  output  1  state is RUN.
REQ-021 halted  output  1  state is HALTED.
REQ-022 overflow  output  1  sticky; at least one entry was dropped or overwritten.

Function
REQ-023 The monitor SHALL implement three states: IDLE, RUN and HALTED.
REQ-024 IDLE -> RUN on a rising edge with start=1 and clear=0; cycle_count becomes 1 on the first RUN cycle and increments by 1 each following RUN cycle.
REQ-025 Every RUN cycle SHALL push one entry {cycle_count, pc, instruction} into the buffer.
REQ-026 RUN -> HALTED after the cycle in which cycle_count==MAX_CYCLES, or in which bp_enable=1 and pc==bp_addr; that cycle's entry is still pushed, and cycle_count freezes.
REQ-027 Push when level==DEPTH with no pop in the same cycle: WRAP_MODE=0 discards the new entry; WRAP_MODE=1 discards the oldest and stores the new one; both set overflow.
REQ-028 Push and pop in the same cycle SHALL leave level unchanged and SHALL never set overflow, including when full.
REQ-029 rd_req with level>0 SHALL pop the oldest entry, presented on rd_data with rd_valid=1 on the next cycle; rd_req with level==0 is ignored, and rd_valid stays 0.
REQ-030 Reads SHALL be accepted in every state.
REQ-031 rd_valid SHALL be a one-cycle pulse per accepted pop; rd_data holds its last value when rd_valid=0.
REQ-032 clear=1 SHALL take priority over start, push and pop, and SHALL return to IDLE with level, cycle_count and overflow zeroed and rd_valid=0 next cycle.
REQ-033 HALTED SHALL persist until clear or reset; start is ignored in RUN and HALTED.
REQ-034 Buffer pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH.

Reset
REQ-035 While reset=1 the monitor SHALL be in IDLE with cycle_count=0, level=0, rd_valid=0, rd_data=0, running=0, halted=0 and overflow=0, without waiting for a clock edge.
REQ-036 Reset asserted during RUN SHALL discard the buffer contents; after reset deasserts, behaviour is as from power-up.

Verification
REQ-037 Defaults with start held and pc incrementing from 0: halted after cycle 70; the first 16 pops return cycles 1..16 with pc 0..15; overflow=1.
REQ-038 WRAP_MODE=1 with DEPTH=4 and MAX_CYCLES=10: after halt, pops return cycles 7, 8, 9, 10, then rd_req yields no rd_valid; overflow=1.
REQ-039 bp_enable=1, bp_addr=8'h05, pc sequence 0,1,2,5: halted after the pc=5 cycle, cycle_count=4, level=4, last entry {4, 8'h05, instr}.
REQ-040 Full buffer (DEPTH=4) with push and rd_req in the same cycle: level stays 4, overflow stays 0, popped entry is the oldest.
REQ-041 clear during RUN at cycle 3: next cycle IDLE with level=0 and cycle_count=0; start then restarts at cycle_count=1.
REQ-042 reset pulse between clock edges during RUN: outputs reach their reset values immediately; a pop after release returns nothing.
